cpu6_bus_unit: RTL and testbench

Memory-mapped bus slave directly downstream of the CPU6 core. It consumes the core's address, write data and write-enable, and returns read data combinationally for the same cycle. It contains the main RAM and a console MUX port at MUX_BASE. The MUX port has a TX FIFO and an 8N1 serial transmitter, plus an optional receiver.

---
 rtl/cpu6_bus_unit.sv | 309 ++++++++++++++++++++++++++++++
 tb/tb_cpu6_bus_unit.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu6_bus_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : cpu6_bus_unit                                                 |
// | Purpose  : Memory-mapped bus slave behind the CPU6 core. Holds the main  |
// |            RAM and the console MUX port (status + data registers), with  |
// |            a TX FIFO feeding an 8N1 serial transmitter and an optional   |
// |            8N1 receiver.                                                 |
// | Options  : define UART_RX_EN to build the serial receiver. Without it,   |
// |            rx is ignored, rx_valid reads 0 and DATA reads 8'h00.         |
// | Ports    : clock         - system clock, rising edge                     |
// |            reset         - asynchronous, active-high                     |
// |            address       - 16-bit bus address from CPU6                  |
// |            write_data    - 8-bit bus write data                          |
// |            write_en      - write strobe, one write per asserted edge     |
// |            read_data     - combinational read data                       |
// |            tx            - serial transmit line, idle high, registered   |
// |            rx            - serial receive line                           |
// |            tx_busy       - transmitter active or FIFO non-empty          |
// |            fifo_overflow - sticky: a DATA write was dropped (FIFO full)  |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module cpu6_bus_unit #(
  parameter int          RAM_ADDR_BITS = 15,
  parameter int          FIFO_DEPTH    = 8,
  parameter int          CLKS_PER_BIT  = 16,
  parameter logic [15:0] MUX_BASE      = 16'hF200
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] address,
  input  logic [7:0]  write_data,
  input  logic        write_en,
  output logic [7:0]  read_data,
  output logic        tx,
  input  logic        rx,
  output logic        tx_busy,
  output logic        fifo_overflow
);

  localparam int unsigned       RAM_SIZE  = 1 << RAM_ADDR_BITS;
  localparam logic [15:0]       MUX_DATA  = MUX_BASE + 16'd1;
  localparam int                PTR_W     = $clog2(FIFO_DEPTH);
  localparam int                BAUD_W    = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [PTR_W:0]    FIFO_FULL = (PTR_W + 1)'(FIFO_DEPTH);

  // ---------------------------------------------------------------- decode
  logic sel_ram, sel_status, sel_data;
  assign sel_ram    = {16'd0, address} < RAM_SIZE;
  assign sel_status = (address == MUX_BASE);
  assign sel_data   = (address == MUX_DATA);

  // ------------------------------------------------------------------ RAM
  logic [7:0] ram [RAM_SIZE];

  always_ff @(posedge clock) begin
    if (write_en && sel_ram) begin
      ram[address[RAM_ADDR_BITS-1:0]] <= write_data;
    end
  end

  // -------------------------------------------------------------- TX FIFO
  logic [7:0]       fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   fifo_count;
  logic             fifo_full, fifo_empty;
  logic             push_req, push, pop;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;
  tx_state_t state, state_n;

  assign fifo_full  = (fifo_count == FIFO_FULL);
  assign fifo_empty = (fifo_count == '0);
  assign push_req   = write_en && sel_data;
  assign pop        = (state == IDLE) && !fifo_empty;
  // A pop on the same edge frees the slot, so a push into a full FIFO is
  // still accepted then; the write pointer equals the read pointer and the
  // popped byte is read before it is overwritten.
  assign push       = push_req && (!fifo_full || pop);

  always_ff @(posedge clock) begin
    if (push) begin
      fifo_mem[wr_ptr] <= write_data;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      fifo_count    <= '0;
      fifo_overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
      if (push_req && !push) fifo_overflow <= 1'b1;
    end
  end

  // ----------------------------------------------------------- TX FSM
  logic [BAUD_W-1:0] baud, baud_n;
  logic [2:0]        bit_idx, bit_n;
  logic [7:0]        shift, shift_n;
  logic              tx_n;
  logic              baud_done;

  assign baud_done = (baud == BAUD_LAST);
  assign tx_busy   = (state != IDLE) || !fifo_empty;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      baud    <= '0;
      bit_idx <= '0;
      shift   <= '0;
      tx      <= 1'b1;
    end else begin
      state   <= state_n;
      baud    <= baud_n;
      bit_idx <= bit_n;
      shift   <= shift_n;
      tx      <= tx_n;
    end
  end

  always_comb begin
    state_n = state;
    baud_n  = baud;
    bit_n   = bit_idx;
    shift_n = shift;
    tx_n    = 1'b1;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          shift_n = fifo_mem[rd_ptr];
          baud_n  = '0;
          state_n = START;
        end
      end
      START: begin
        if (baud_done) begin
          baud_n  = '0;
          bit_n   = '0;
          state_n = DATA;
        end else begin
          baud_n = baud + 1'b1;
        end
      end
      DATA: begin
        if (baud_done) begin
          baud_n = '0;
          if (bit_idx == 3'd7) begin
            state_n = STOP;
          end else begin
            bit_n   = bit_idx + 3'd1;
            shift_n = shift >> 1;
          end
        end else begin
          baud_n = baud + 1'b1;
        end
      end
      STOP: begin
        if (baud_done) begin
          baud_n  = '0;
          state_n = IDLE;
        end else begin
          baud_n = baud + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
    // tx is registered from the next state so the line level lines up with
    // the state the FSM occupies after the edge.
    case (state_n)
      START:   tx_n = 1'b0;
      DATA:    tx_n = shift_n[0];
      default: tx_n = 1'b1;
    endcase
  end

  // ------------------------------------------------------------- receiver
  logic       rx_valid;
  logic [7:0] rx_data;

`ifdef UART_RX_EN
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  localparam logic [BAUD_W-1:0] BAUD_HALF = BAUD_W'(CLKS_PER_BIT / 2 - 1);

  rx_state_t         rx_state, rx_state_n;
  logic              rx_meta, rx_sync, rx_prev;
  logic [BAUD_W-1:0] rx_baud, rx_baud_n;
  logic [2:0]        rx_bit, rx_bit_n;
  logic [7:0]        rx_shift, rx_shift_n;
  logic              rx_done;
  logic              data_prev;
  logic              rx_pop;

  // One pop per access: only the first cycle of a run of DATA addresses.
  assign rx_pop = sel_data && !data_prev;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rx_meta   <= 1'b1;
      rx_sync   <= 1'b1;
      rx_prev   <= 1'b1;
      rx_state  <= RX_IDLE;
      rx_baud   <= '0;
      rx_bit    <= '0;
      rx_shift  <= '0;
      data_prev <= 1'b0;
      rx_valid  <= 1'b0;
      rx_data   <= '0;
    end else begin
      rx_meta   <= rx;
      rx_sync   <= rx_meta;
      rx_prev   <= rx_sync;
      rx_state  <= rx_state_n;
      rx_baud   <= rx_baud_n;
      rx_bit    <= rx_bit_n;
      rx_shift  <= rx_shift_n;
      data_prev <= sel_data;
      // A completing byte wins over a simultaneous pop.
      if (rx_done) begin
        rx_data  <= rx_shift;
        rx_valid <= 1'b1;
      end else if (rx_pop) begin
        rx_valid <= 1'b0;
      end
    end
  end

  always_comb begin
    rx_state_n = rx_state;
    rx_baud_n  = rx_baud;
    rx_bit_n   = rx_bit;
    rx_shift_n = rx_shift;
    rx_done    = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        // Edge-triggered so a low stop bit cannot retrigger a frame.
        if (rx_prev && !rx_sync) begin
          rx_baud_n  = '0;
          rx_state_n = RX_START;
        end
      end
      RX_START: begin
        if (rx_baud == BAUD_HALF) begin
          if (rx_sync) begin
            rx_state_n = RX_IDLE;
          end else begin
            rx_baud_n  = '0;
            rx_bit_n   = '0;
            rx_state_n = RX_DATA;
          end
        end else begin
          rx_baud_n = rx_baud + 1'b1;
        end
      end
      RX_DATA: begin
        if (rx_baud == BAUD_LAST) begin
          rx_baud_n  = '0;
          rx_shift_n = {rx_sync, rx_shift[7:1]};
          if (rx_bit == 3'd7) begin
            rx_state_n = RX_STOP;
          end else begin
            rx_bit_n = rx_bit + 3'd1;
          end
        end else begin
          rx_baud_n = rx_baud + 1'b1;
        end
      end
      RX_STOP: begin
        if (rx_baud == BAUD_LAST) begin
          rx_baud_n  = '0;
          rx_state_n = RX_IDLE;
          rx_done    = rx_sync;
        end else begin
          rx_baud_n = rx_baud + 1'b1;
        end
      end
      default: rx_state_n = RX_IDLE;
    endcase
  end
`else
  logic unused_rx;
  assign unused_rx = rx;
  assign rx_valid  = 1'b0;
  assign rx_data   = 8'h00;
`endif

  // ------------------------------------------------------------ read mux
  always_comb begin
    read_data = 8'hFF;
    if (sel_ram) begin
      read_data = ram[address[RAM_ADDR_BITS-1:0]];
    end else if (sel_status) begin
      read_data = {tx_busy, 5'b00000, ~fifo_full, rx_valid};
    end else if (sel_data) begin
      read_data = rx_data;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cpu6_bus_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_cpu6_bus_unit                                              |
// | Purpose  : Self-checking bench for cpu6_bus_unit. Bytes written to the   |
// |            DATA register are queued as expected frames; a tx monitor     |
// |            decodes each serial frame and compares it with the queue.     |
// |            Build with UART_RX_EN to exercise the receiver.               |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_cpu6_bus_unit;

  localparam int CPB   = 4;
  localparam int FRAME = 10 * CPB;

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] address;
  logic [7:0]  write_data;
  logic        write_en;
  logic [7:0]  read_data;
  logic        tx;
  logic        rx;
  logic        tx_busy;
  logic        fifo_overflow;

  int         vectors     = 0;
  int         miscompares = 0;
  int         cyc         = 0;
  logic [7:0] exp_q[$];
  int         start_cyc_q[$];

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  cpu6_bus_unit #(
    .RAM_ADDR_BITS(15),
    .FIFO_DEPTH   (8),
    .CLKS_PER_BIT (CPB),
    .MUX_BASE     (16'hF200)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .address      (address),
    .write_data   (write_data),
    .write_en     (write_en),
    .read_data    (read_data),
    .tx           (tx),
    .rx           (rx),
    .tx_busy      (tx_busy),
    .fifo_overflow(fifo_overflow)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
    address = a; write_data = d; write_en = 1'b1;
    @(negedge clock);
    write_en = 1'b0;
  endtask

  task automatic bus_read(input string tag, input logic [15:0] a, input logic [7:0] exp);
    address = a;
    #1;
    check_val(tag, read_data, exp);
  endtask

`ifdef UART_RX_EN
  task automatic send_rx(input logic [7:0] b, input logic stop_bit);
    logic [9:0] f;
    f = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx = f[i];
      repeat (CPB) @(negedge clock);
    end
    rx = 1'b1;
    repeat (2 * CPB) @(negedge clock);
  endtask
`endif

  // tx monitor: decodes 8N1 frames at mid-bit and checks them against exp_q.
  initial begin : tx_monitor
    logic       prev_tx;
    logic       ok;
    logic [7:0] byte_v;
    int         b;
    prev_tx = 1'b1;
    forever begin
      @(negedge clock);
      if (!reset && prev_tx && !tx) begin
        start_cyc_q.push_back(cyc);
        ok     = 1'b1;
        byte_v = 8'h00;
        for (int c = 1; c < FRAME; c++) begin
          @(negedge clock);
          if (reset) begin
            ok = 1'b0;
            break;
          end
          if (c % CPB == CPB / 2) begin
            b = c / CPB;
            if (b == 0)      check_val("tx_start_bit", tx, 1'b0);
            else if (b == 9) check_val("tx_stop_bit", tx, 1'b1);
            else             byte_v[b-1] = tx;
          end
        end
        if (ok) begin
          check_val("tx_frame_expected", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) check_val("tx_frame_byte", byte_v, exp_q.pop_front());
        end
      end
      prev_tx = tx;
    end
  end

  initial begin : main
    logic [7:0] pat;
    logic       e;
    int         slot;
    reset = 1'b1; address = 16'h0000; write_data = 8'h00; write_en = 1'b0; rx = 1'b1;
    repeat (2) @(negedge clock);

    // Reset state
    check_val("rst_tx", tx, 1'b1);
    check_val("rst_busy", tx_busy, 1'b0);
    check_val("rst_ovf", fifo_overflow, 1'b0);
    bus_read("rst_status", 16'hF200, 8'h02);
    bus_read("rst_data", 16'hF201, 8'h00);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    // RAM and decode
    bus_write(16'h1234, 8'h5A);
    bus_write(16'h0000, 8'h11);
    bus_write(16'h7FFF, 8'hEE);
    bus_write(16'h8000, 8'h77);
    bus_write(16'hF200, 8'h33);
    bus_read("ram_1234", 16'h1234, 8'h5A);
    bus_read("ram_0000", 16'h0000, 8'h11);
    bus_read("ram_7fff", 16'h7FFF, 8'hEE);
    bus_read("unmapped_8000", 16'h8000, 8'hFF);
    bus_read("unmapped_f202", 16'hF202, 8'hFF);
    bus_read("unmapped_ffff", 16'hFFFF, 8'hFF);
    bus_read("status_after_wr", 16'hF200, 8'h02);

    // Single frame, exact waveform
    @(negedge clock);
    pat = 8'h55;
    exp_q.push_back(pat);
    address = 16'hF201; write_data = pat; write_en = 1'b1;
    @(negedge clock);                      // edge N passed
    write_en = 1'b0; address = 16'h0000;
    check_val("tx_before_pop", tx, 1'b1);
    check_val("busy_queued", tx_busy, 1'b1);
    for (int c = 0; c < FRAME; c++) begin
      @(negedge clock);                    // after edge N+1+c
      slot = c / CPB;
      if (slot == 0)      e = 1'b0;
      else if (slot == 9) e = 1'b1;
      else                e = pat[slot-1];
      check_val("tx_wave", tx, e);
    end
    check_val("busy_last_stop", tx_busy, 1'b1);
    @(negedge clock);
    check_val("busy_drop", tx_busy, 1'b0);
    repeat (2) @(negedge clock);

    // Back-to-back frames
    start_cyc_q.delete();
    exp_q.push_back(8'h41);
    exp_q.push_back(8'h42);
    address = 16'hF201; write_data = 8'h41; write_en = 1'b1;
    @(negedge clock);
    write_data = 8'h42;
    @(negedge clock);
    write_en = 1'b0; address = 16'hF200;
    for (int c = 0; c < 3 * FRAME && tx_busy; c++) begin
      #1;
      check_val("b2b_not_full", read_data[1], 1'b1);
      @(negedge clock);
    end
    check_val("b2b_done", tx_busy, 1'b0);
    repeat (2) @(negedge clock);
    check_val("b2b_frames", start_cyc_q.size(), 2);
    if (start_cyc_q.size() == 2) check_val("b2b_gap", start_cyc_q[1] - start_cyc_q[0], FRAME + 1);

    // Overflow: 10 writes, 9 accepted
    for (int i = 0; i < 10; i++) begin
      if (i < 9) exp_q.push_back(8'(8'h60 + i));
      address = 16'hF201; write_data = 8'(8'h60 + i); write_en = 1'b1;
      @(negedge clock);
      if (i == 8) check_val("ovf_before", fifo_overflow, 1'b0);
    end
    write_en = 1'b0;
    check_val("ovf_set", fifo_overflow, 1'b1);
    bus_read("status_full", 16'hF200, 8'h80);
    for (int c = 0; c < 12 * FRAME && tx_busy; c++) @(negedge clock);
    check_val("ovf_drained", tx_busy, 1'b0);
    check_val("ovf_sticky", fifo_overflow, 1'b1);
    repeat (2) @(negedge clock);
    check_val("ovf_all_frames", exp_q.size(), 0);

    // Reset during DATA bit 3
    bus_write(16'h0100, 8'hC3);
    address = 16'hF201; write_data = 8'hA0; write_en = 1'b1;
    @(negedge clock);
    write_data = 8'hA1;
    @(negedge clock);
    write_data = 8'hA2;
    @(negedge clock);
    write_en = 1'b0; address = 16'h0100;
    repeat (16) @(negedge clock);          // inside DATA bit 3 of 0xA0
    check_val("mid_bit3", tx, 1'b0);
    #2 reset = 1'b1;
    #1;
    check_val("mid_rst_tx", tx, 1'b1);
    check_val("mid_rst_busy", tx_busy, 1'b0);
    check_val("mid_rst_ovf", fifo_overflow, 1'b0);
    bus_read("mid_rst_status", 16'hF200, 8'h02);
    @(negedge clock);
    #2 reset = 1'b0;
    bus_read("ram_kept", 16'h0100, 8'hC3);
    repeat (2 * FRAME) @(negedge clock);
    check_val("post_rst_idle_tx", tx, 1'b1);
    check_val("post_rst_idle_busy", tx_busy, 1'b0);

`ifdef UART_RX_EN
    address = 16'hF200;
    @(negedge clock);
    send_rx(8'hA3, 1'b1);
    bus_read("rx_status_valid", 16'hF200, 8'h03);
    bus_read("rx_data", 16'hF201, 8'hA3);
    @(negedge clock);
    bus_read("rx_popped", 16'hF200, 8'h02);
    @(negedge clock);
    send_rx(8'h5C, 1'b0);
    bus_read("rx_framing_err", 16'hF200, 8'h02);
    bus_read("rx_data_kept", 16'hF201, 8'hA3);
    @(negedge clock);
`else
    rx = 1'b0;
    bus_read("norx_data", 16'hF201, 8'h00);
    bus_read("norx_status", 16'hF200, 8'h02);
    rx = 1'b1;
    @(negedge clock);
`endif

    check_val("scoreboard_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
